// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared state encoding and default width for the bit-serial adder
package serial_add_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
  localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/full_add.sv
// full_add: one-bit full-adder cell
module full_add (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic carry_o
);
  assign sum_o   = a_i ^ b_i ^ cin_i;
  assign carry_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder, one full-adder cell stepped LSB first over WIDTH bits
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, ssr_q, ssr_d, sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
  logic             fa_s, fa_c;
  full_add u_fa (.a_i(a_q[0]), .b_i(b_q[0]), .cin_i(c_q), .sum_o(fa_s), .carry_o(fa_c));
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ssr_d   = ssr_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: if (in_valid) begin
        a_d     = a;
        b_d     = b;
        c_d     = cin;
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        ssr_d = {fa_s, ssr_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = fa_c;
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        // c_q here is the carry into the MSB, so this is the signed overflow
        if (cnt_q == LAST) begin
          ovf_d   = c_q ^ fa_c;
          cout_d  = fa_c;
          sum_d   = {fa_s, ssr_q[WIDTH-1:1]};
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = out_ready ? ST_IDLE : ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ssr_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ssr_q   <= ssr_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
  assign in_ready  = state_q == ST_IDLE;
  assign out_valid = state_q == ST_DONE;
  assign busy      = state_q != ST_IDLE;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
endmodule
